instr_fetch_unit: RTL
=====================

Name: instr_fetch_unit

Overview:
- Upstream neighbour of the opcode decoder/controller.
- Holds the program counter and fetches 32-bit instruction words from instruction memory over a req/ready handshake.
- Latches each word into an instruction register and presents the sliced fields (opcode, rs, rt, rd, shamt, imm) to the decoder and register file with a valid/ready handshake.
- Supports PC redirect and stops fetching on a HALT word.

Parameters:
- ADDR_WIDTH, 32, width of PC and instruction-memory address.
- RESET_PC, 0, PC value after reset; bits [1:0] are ignored and treated as 0.
- HALT_OPCODE, 6'b111111, opcode that stops fetching.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- imem_req  output  1  fetch request; imem_addr is valid while high.
- imem_addr  output  ADDR_WIDTH  word-aligned fetch address; always equals pc.
- imem_rdata  input  32  instruction word; meaningful only when imem_ready=1.
- imem_ready  input  1  memory returns the word for the address presented this cycle.
- instr_valid  output  1  fields below hold a valid instruction.
- instr_ready  input  1  downstream accepts the instruction this cycle.
- opcode  output  6  IR[31:26].
- rs  output  5  IR[25:21].
- rt  output  5  IR[20:16].
- rd  output  5  IR[15:11].
- shamt  output  5  IR[10:6].
- imm  output  16  IR[15:0].
- imm_sext  output  32  imm sign-extended.
- pc_out  output  ADDR_WIDTH  address the current IR was fetched from.
- redirect_valid  input  1  load a new PC and flush.
- redirect_pc  input  ADDR_WIDTH  new PC; bits [1:0] are forced to 0.
- halted  output  1  high while in HALT.

Behaviour:
- **States:** IDLE, FETCH, ISSUE, HALT.
- **Reset (async):**
  - state=IDLE, pc=RESET_PC, IR=0, pc_out=0, halted=0.
  - instr_valid=0 and imem_req=0.
  - With IR=0, opcode=0, which decodes downstream as no-op/all control low.
- **IDLE:** imem_req=0; unconditionally go to FETCH on the next edge.
- **FETCH:**
  - imem_req=1, imem_addr=pc.
  - If imem_ready=0: stay in FETCH; pc is unchanged (any number of wait cycles).
  - If imem_ready=1 and imem_rdata[31:26]!=HALT_OPCODE: IR<=imem_rdata, pc_out<=pc, pc<=pc+4, go to ISSUE.
  - If imem_ready=1 and opcode==HALT_OPCODE: IR is not loaded, pc is unchanged (points at the HALT word), go to HALT.
- **ISSUE:**
  - instr_valid=1, imem_req=0.
  - IR and pc_out are held stable until accepted.
  - When instr_ready=1: go to FETCH on the same edge.
- **Throughput:** minimum 2 cycles per instruction (FETCH with ready, then ISSUE with ready).
- **HALT:** imem_req=0, instr_valid=0, halted=1. Leave only via redirect or reset.
- **Field outputs:** combinational slices of IR, valid in every state. Downstream qualifies them with instr_valid.
- **PC arithmetic:** pc+4 modulo 2^ADDR_WIDTH; wraps silently from all-ones-aligned to 0.
- **Redirect (highest priority, any state incl. HALT/IDLE):**
  - pc<=redirect_pc & ~3, state<=FETCH, halted<=0.
  - IR is not updated.
  - An imem_ready in the same cycle is discarded.
  - An instruction in ISSUE is dropped even if instr_ready=1 that cycle; downstream must treat instr_valid&instr_ready&redirect_valid as no transfer.
  - instr_valid is 0 in the following cycle.
- **Reset mid-operation:** immediate return to the reset values; any outstanding fetch is abandoned. Memory must tolerate req dropping.
- **Protocol rules:**
  - imem_req is a pure function of state.
  - imem_addr changes only on a handshake edge or a redirect.

Test Plan:
- **Zero-wait fetch:** reset, memory with imem_ready=1 every cycle returning 0x0421_1800 at addr 0 and 0x2C22_0005 at addr 4, instr_ready=1 → first instr_valid 3 cycles after rst release; opcode=1, rs=1, rt=1, rd=3, pc_out=0. Next valid 2 cycles later: opcode=0x0B, imm=5, imm_sext=0x0000_0005, pc_out=4.
- **Wait states and backpressure:** imem_ready delayed 3 cycles and instr_ready held 0 for 4 cycles → imem_addr stable at 8 during the wait; fields and pc_out=8 stable while valid; pc becomes 12 only after capture; no extra fetch before acceptance.
- **Sign extension:** word with imm=0xFFFC → imm_sext=0xFFFF_FFFC.
- **Redirect during ISSUE with instr_ready=1:** redirect_pc=0x103 → next cycle instr_valid=0, imem_req=1, imem_addr=0x100; the dropped instruction is never re-presented.
- **HALT:** word 0xFC00_0000 at addr 0x10 → halted=1, imem_req=0, instr_valid=0 indefinitely, pc=0x10. Then redirect_pc=0x20 → halted=0, fetch resumes at 0x20.
- **Wrap and async reset:** RESET_PC=0xFFFF_FFFC, fetch one word → next imem_addr=0. Assert rst mid-FETCH between clock edges → imem_req and instr_valid drop immediately, pc=RESET_PC.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// ---------------------------------------------------------------------------
// instr_fetch_unit
//
// Holds the program counter, fetches 32-bit instruction words from
// instruction memory over a req/ready handshake, latches each word into the
// instruction register and presents its decoded fields downstream with a
// valid/ready handshake. Supports a PC redirect and stops on a HALT word.
//
// Ports:
//   clk            - single clock, rising edge
//   rst            - asynchronous active-high reset
//   imem_req       - fetch request, imem_addr valid while high
//   imem_addr      - word-aligned fetch address (always equals pc)
//   imem_rdata     - instruction word, meaningful when imem_ready=1
//   imem_ready     - memory returns the word for the presented address
//   instr_valid    - fields hold a valid instruction
//   instr_ready    - downstream accepts the instruction this cycle
//   opcode/rs/rt/rd/shamt/imm/imm_sext - slices of the instruction register
//   pc_out         - address the current instruction was fetched from
//   redirect_valid - load redirect_pc and flush
//   redirect_pc    - new PC, low two bits forced to zero
//   halted         - high while stopped on a HALT word
// ---------------------------------------------------------------------------
module instr_fetch_unit #(
    parameter int                    ADDR_WIDTH  = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0,
    parameter logic [5:0]            HALT_OPCODE = 6'b111111
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  imem_req,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    input  logic [31:0]           imem_rdata,
    input  logic                  imem_ready,
    output logic                  instr_valid,
    input  logic                  instr_ready,
    output logic [5:0]            opcode,
    output logic [4:0]            rs,
    output logic [4:0]            rt,
    output logic [4:0]            rd,
    output logic [4:0]            shamt,
    output logic [15:0]           imm,
    output logic [31:0]           imm_sext,
    output logic [ADDR_WIDTH-1:0] pc_out,
    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH-1:0] redirect_pc,
    output logic                  halted
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_ISSUE,
        S_HALT
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK       = ~(ADDR_WIDTH'(3));
    localparam logic [ADDR_WIDTH-1:0] RESET_PC_ALIGNED = RESET_PC & ALIGN_MASK;
    localparam logic [ADDR_WIDTH-1:0] PC_STEP          = ADDR_WIDTH'(4);

    state_t                  state;
    state_t                  state_next;
    logic [ADDR_WIDTH-1:0]   pc;
    logic [31:0]             ir;
    logic                    fetch_done;
    logic                    fetch_is_halt;
    logic                    capture;

    // A memory response only counts while fetching and when no redirect is
    // pending; a HALT word is recognised but never enters the IR.
    assign fetch_done    = (state == S_FETCH) && imem_ready && !redirect_valid;
    assign fetch_is_halt = (imem_rdata[31:26] == HALT_OPCODE);
    assign capture       = fetch_done && !fetch_is_halt;

    // State register: reset throws away any fetch in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic. Redirect overrides everything, including HALT and a
    // same-cycle acceptance in ISSUE, so the issued instruction is dropped.
    always_comb begin
        state_next = state;
        if (redirect_valid) begin
            state_next = S_FETCH;
        end else begin
            case (state)
                S_IDLE:  state_next = S_FETCH;
                S_FETCH: begin
                    if (imem_ready) begin
                        state_next = fetch_is_halt ? S_HALT : S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (instr_ready) begin
                        state_next = S_FETCH;
                    end
                end
                S_HALT:  state_next = S_HALT;
                default: state_next = S_IDLE;
            endcase
        end
    end

    // Output logic: request and valid depend only on the state so the memory
    // and the decoder never see a combinational path from their own inputs.
    always_comb begin
        imem_req    = 1'b0;
        instr_valid = 1'b0;
        halted      = 1'b0;
        case (state)
            S_FETCH: imem_req    = 1'b1;
            S_ISSUE: instr_valid = 1'b1;
            S_HALT:  halted      = 1'b1;
            default: ;
        endcase
    end

    // PC, instruction register and issue address. The PC advances only when
    // a real instruction is captured, so it stays pointing at a HALT word.
    // The increment wraps silently at the top of the address space.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc     <= RESET_PC_ALIGNED;
            ir     <= '0;
            pc_out <= '0;
        end else if (redirect_valid) begin
            pc <= redirect_pc & ALIGN_MASK;
        end else if (capture) begin
            ir     <= imem_rdata;
            pc_out <= pc;
            pc     <= pc + PC_STEP;
        end
    end

    assign imem_addr = pc;

    // Field slices are always driven; downstream qualifies with instr_valid.
    assign opcode   = ir[31:26];
    assign rs       = ir[25:21];
    assign rt       = ir[20:16];
    assign rd       = ir[15:11];
    assign shamt    = ir[10:6];
    assign imm      = ir[15:0];
    assign imm_sext = {{16{ir[15]}}, ir[15:0]};

endmodule
